// File: rtl/pellet_pkg.sv
// Shared types and constant maze data for the pellet tracker and its helpers.
// Map bit [row][col] is 1 where a pellet is placed at level start.
package pellet_pkg;

  localparam int unsigned MAP_COLS = 40;
  localparam int unsigned MAP_ROWS = 30;

  typedef enum logic [1:0] {PLAY, CLEAR, REFILL} state_t;

  typedef logic [MAP_ROWS-1:0][MAP_COLS-1:0] map_t;

  // Border ring is wall, the ghost house (rows 12..16, cols 16..23) is empty,
  // and the Pac-Man start tile (col 8, row 14) carries no pellet.
  function automatic map_t build_init();
    map_t m;
    m = '0;
    for (int unsigned r = 1; r < MAP_ROWS - 1; r++) begin
      for (int unsigned c = 1; c < MAP_COLS - 1; c++) begin
        m[r][c] = 1'b1;
      end
    end
    for (int unsigned r = 12; r <= 16; r++) begin
      for (int unsigned c = 16; c <= 23; c++) begin
        m[r][c] = 1'b0;
      end
    end
    m[14][8] = 1'b0;
    return m;
  endfunction

  function automatic map_t build_power();
    map_t m;
    m = '0;
    m[3][1]   = 1'b1;
    m[3][38]  = 1'b1;
    m[22][1]  = 1'b1;
    m[22][38] = 1'b1;
    return m;
  endfunction

  function automatic int unsigned count_bits(map_t m);
    int unsigned n;
    n = 0;
    for (int unsigned r = 0; r < MAP_ROWS; r++) begin
      for (int unsigned c = 0; c < MAP_COLS; c++) begin
        n += int'(m[r][c]);
      end
    end
    return n;
  endfunction

  localparam map_t        PELLET_INIT  = build_init();
  localparam map_t        POWER_MASK   = build_power();
  localparam int unsigned PELLET_TOTAL = count_bits(PELLET_INIT);

endpackage

// File: rtl/pellet_tracker_bcd_add4.sv
// Combinational 4-digit BCD adder; a result above 9999 saturates to 9999.
// Operands are assumed to be valid BCD.
module bcd_add4 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o
);

  logic [4:0]  digit;
  logic        carry;
  logic [15:0] raw;

  always_comb begin
    carry = 1'b0;
    digit = '0;
    raw   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      digit = {1'b0, a_i[4*i +: 4]} + {1'b0, b_i[4*i +: 4]} + {4'b0, carry};
      if (digit > 5'd9) begin
        digit = digit + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      raw[4*i +: 4] = digit[3:0];
    end
    sum_o = carry ? 16'h9999 : raw;
  end

endmodule

// File: rtl/pellet_tracker.sv
// Live pellet map, BCD score, pellet count and level sequencing driven by
// Pac-Man's per-frame tile position; renderer queries the map combinationally.
module pellet_tracker
  import pellet_pkg::*;
#(
  parameter int unsigned CLEAR_FRAMES = 120,
  parameter logic [15:0] PTS_PELLET   = 16'h0010,
  parameter logic [15:0] PTS_POWER    = 16'h0050
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [9:0]  pac_x,
  input  logic [9:0]  pac_y,
  input  logic        crossing,
  input  logic        game_en,
  input  logic [5:0]  q_col,
  input  logic [4:0]  q_row,
  output logic        q_pellet,
  output logic        q_power,
  output logic [15:0] score_bcd,
  output logic [10:0] pellets_left,
  output logic [3:0]  level,
  output logic        eat_pulse,
  output logic        power_pulse,
  output logic        level_clear
);

  localparam int unsigned CW = (CLEAR_FRAMES > 2) ? $clog2(CLEAR_FRAMES) : 1;

  state_t          state_q, state_d;
  map_t            map_q, map_d;
  logic [15:0]     score_q, score_d, score_sum;
  logic [10:0]     left_q, left_d;
  logic [3:0]      level_q, level_d;
  logic            eat_q, eat_d, pow_q, pow_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [5:0] col;
  logic [4:0] row;
  logic       tile_ok, is_pow, eat, q_ok;

  // Row uses only pac_y[8:4]; the <480 check guarantees bit 9 is clear.
  assign col     = pac_x[9:4];
  assign row     = pac_y[8:4];
  assign tile_ok = (pac_x < 10'd640) && (pac_y < 10'd480);
  assign is_pow  = POWER_MASK[row][col];
  assign eat     = (state_q == PLAY) && game_en && crossing && tile_ok && map_q[row][col];

  bcd_add4 u_add (
    .a_i   (score_q),
    .b_i   (is_pow ? PTS_POWER : PTS_PELLET),
    .sum_o (score_sum)
  );

  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    score_d = score_q;
    left_d  = left_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    eat_d   = 1'b0;
    pow_d   = 1'b0;
    case (state_q)
      PLAY: begin
        if (eat) begin
          map_d[row][col] = 1'b0;
          left_d          = left_q - 11'd1;
          score_d         = score_sum;
          eat_d           = 1'b1;
          pow_d           = is_pow;
          if (left_q == 11'd1) begin
            state_d = CLEAR;
            cnt_d   = '0;
          end
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(CLEAR_FRAMES - 1)) state_d = REFILL;
      end
      REFILL: begin
        map_d   = PELLET_INIT;
        left_d  = 11'(PELLET_TOTAL);
        level_d = level_q + 4'd1;
        state_d = PLAY;
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= PLAY;
      map_q   <= PELLET_INIT;
      score_q <= '0;
      left_q  <= 11'(PELLET_TOTAL);
      level_q <= '0;
      cnt_q   <= '0;
      eat_q   <= 1'b0;
      pow_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      score_q <= score_d;
      left_q  <= left_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      eat_q   <= eat_d;
      pow_q   <= pow_d;
    end
  end

  assign q_ok         = (q_col < 6'(MAP_COLS)) && (q_row < 5'(MAP_ROWS));
  assign q_pellet     = q_ok && map_q[q_row][q_col];
  assign q_power      = q_pellet && POWER_MASK[q_row][q_col];
  assign score_bcd    = score_q;
  assign pellets_left = left_q;
  assign level        = level_q;
  assign eat_pulse    = eat_q;
  assign power_pulse  = pow_q;
  assign level_clear  = (state_q == CLEAR);

endmodule
